// File: rtl/iir_pkg.sv
// Shared constants, state encoding and helpers for the biquad coefficient loader.
// Optional feature macro used by the loader: IIR_COEF_CHECKSUM_EN.
package iir_pkg;

    localparam int DW           = 16;
    localparam int NSEC         = 7;
    localparam int COEF_PER_SEC = 5;
    localparam logic [3:0] HDR_MAGIC = 4'hA;

    // Position of each coefficient inside a section's five-word group
    localparam int B0 = 0;
    localparam int B1 = 1;
    localparam int B2 = 2;
    localparam int A1 = 3;
    localparam int A2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_PEND  = 2'd3
    } state_t;

    // Coefficient words in a frame for a given filter order (two poles per section)
    function automatic int coef_count(input logic [3:0] ord);
        return COEF_PER_SEC * ((int'(ord) + 1) / 2);
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Flat coefficient register file with a single-word write port, whole-bank clear
// and whole-bank copy; copy has priority over clear, clear over write.
module iir_coef_bank #(
    parameter int DW     = 16,
    parameter int NWORDS = 35,
    parameter int AW     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 copy_en,
    input  logic [NWORDS*DW-1:0] copy_data,
    output logic [NWORDS*DW-1:0] q
);

    logic [NWORDS*DW-1:0] r_mem;

    // Bank storage update
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem <= '0;
        end else if (copy_en) begin
            r_mem <= copy_data;
        end else if (clr) begin
            r_mem <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NWORDS; i++) begin
                if (wr_addr == AW'(i)) begin
                    r_mem[i*DW +: DW] <= wr_data;
                end
            end
        end else begin
            r_mem <= r_mem;
        end
    end

    assign q = r_mem;

endmodule

// File: rtl/iir_coef_loader.sv
// Streams header + coefficients into a shadow bank and commits it to the active bank
// on a sample tick. Define IIR_COEF_CHECKSUM_EN to require a trailing checksum word.
module iir_coef_loader
    import iir_pkg::*;
#(
    parameter int DW   = iir_pkg::DW,
    parameter int NSEC = iir_pkg::NSEC
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DW-1:0]                  s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           sample_tick,
    output logic [NSEC*COEF_PER_SEC*DW-1:0] coef_out,
    output logic [3:0]                     order_out,
    output logic                           flush_n,
    output logic                           busy,
    output logic                           err
);

    localparam int NWORDS = NSEC * COEF_PER_SEC;
    localparam int AW     = $clog2(NWORDS);
    localparam logic [3:0] MAX_ORDER = 4'(2 * NSEC);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_order;
    logic [AW-1:0]          r_cnt;
    logic [3:0]             r_order_out;
    logic                   r_flush_n;
    logic                   r_err;
    logic [NWORDS*DW-1:0]   w_shadow;
    logic                   w_xfer;
    logic                   w_hdr_ok;
    logic                   w_hdr_accept;
    logic                   w_shadow_wr;
    logic                   w_last_word;
    logic                   w_commit;
    logic                   w_sum_ok;
    logic                   w_sum_bad;
    logic                   w_shadow_clr;
    logic [AW-1:0]          w_n_last;

    assign w_xfer       = s_valid & s_ready;
    assign w_hdr_ok     = (s_data[DW-1 -: 4] == HDR_MAGIC) && (s_data[3:0] != 4'd0)
                          && (s_data[3:0] <= MAX_ORDER);
    assign w_hdr_accept = (r_state == ST_IDLE) && w_xfer && w_hdr_ok;
    assign w_shadow_wr  = (r_state == ST_LOAD) && w_xfer;
    assign w_n_last     = AW'(coef_count(r_order) - 1);
    assign w_last_word  = w_shadow_wr && (r_cnt == w_n_last);
    assign w_commit     = (r_state == ST_PEND) && sample_tick;
    assign w_sum_bad    = (r_state == ST_CHECK) && w_xfer && !w_sum_ok;
    assign w_shadow_clr = w_hdr_accept || w_sum_bad;

`ifdef IIR_COEF_CHECKSUM_EN
    logic [DW-1:0] r_sum;

    // Running wrapping sum of header and coefficients
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (w_hdr_accept) begin
            r_sum <= s_data;
        end else if (w_shadow_wr) begin
            r_sum <= r_sum + s_data;
        end else begin
            r_sum <= r_sum;
        end
    end

    assign w_sum_ok = (s_data == r_sum);
`else
    assign w_sum_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_accept) w_state_nxt = ST_LOAD;
                else              w_state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                if (w_last_word) begin
`ifdef IIR_COEF_CHECKSUM_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_PEND;
`endif
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_CHECK: begin
`ifdef IIR_COEF_CHECKSUM_EN
                if (w_xfer) w_state_nxt = w_sum_ok ? ST_PEND : ST_IDLE;
                else        w_state_nxt = ST_CHECK;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_PEND: begin
                if (sample_tick) w_state_nxt = ST_IDLE;
                else             w_state_nxt = ST_PEND;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and status decode from the current state
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        case (r_state)
            ST_IDLE:  begin s_ready = 1'b1; busy = 1'b0; end
            ST_LOAD:  begin s_ready = 1'b1; busy = 1'b1; end
            ST_CHECK: begin s_ready = 1'b1; busy = 1'b1; end
            ST_PEND:  begin s_ready = 1'b0; busy = 1'b1; end
            default:  begin s_ready = 1'b0; busy = 1'b0; end
        endcase
    end

    // Order latch, word counter and registered flush/err pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_order     <= 4'd0;
            r_cnt       <= '0;
            r_order_out <= 4'd0;
            r_flush_n   <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_flush_n <= !w_commit;
            r_err     <= ((r_state == ST_IDLE) && w_xfer && !w_hdr_ok) || w_sum_bad;
            if (w_hdr_accept) begin
                r_order <= s_data[3:0];
                r_cnt   <= '0;
            end else if (w_shadow_wr) begin
                r_cnt <= r_cnt + AW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_commit) r_order_out <= r_order;
            else          r_order_out <= r_order_out;
        end
    end

    iir_coef_bank #(.DW(DW), .NWORDS(NWORDS), .AW(AW)) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .clr       (w_shadow_clr),
        .wr_en     (w_shadow_wr),
        .wr_addr   (r_cnt),
        .wr_data   (s_data),
        .copy_en   (1'b0),
        .copy_data ({(NWORDS*DW){1'b0}}),
        .q         (w_shadow)
    );

    iir_coef_bank #(.DW(DW), .NWORDS(NWORDS), .AW(AW)) u_active (
        .clk       (clk),
        .reset     (reset),
        .clr       (1'b0),
        .wr_en     (1'b0),
        .wr_addr   ({AW{1'b0}}),
        .wr_data   ({DW{1'b0}}),
        .copy_en   (w_commit),
        .copy_data (w_shadow),
        .q         (coef_out)
    );

    assign order_out = r_order_out;
    assign flush_n   = r_flush_n;
    assign err       = r_err;

endmodule

// File: tb/tb_iir_coef_loader.sv
// Scoreboard bench for iir_coef_loader: frames are built from a word-array model,
// expected commit/err events are queued at issue time and matched by a monitor.
module tb_iir_coef_loader;

    localparam int DW = 16;
    localparam int NSEC = 7;
    localparam int NW = NSEC * 5;
    localparam int BW = NW * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          sample_tick = 1'b0;
    logic          s_ready;
    logic [BW-1:0] coef_out;
    logic [3:0]    order_out;
    logic          flush_n;
    logic          busy;
    logic          err;

    iir_coef_loader #(.DW(DW), .NSEC(NSEC)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .sample_tick(sample_tick), .coef_out(coef_out), .order_out(order_out),
        .flush_n(flush_n), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [BW-1:0] coef;
        logic [3:0]    order;
    } ev_t;

    ev_t           q[$];
    int            checks = 0;
    int            failures = 0;
    logic [BW-1:0] exp_coef = '0;
    logic [3:0]    exp_order = 4'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: consumes queued events on flush/err and checks the active bank every cycle
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            q.delete();
            exp_coef = '0;
            exp_order = 4'd0;
        end else begin
            if (!flush_n) begin
                checks++;
                if (q.size() == 0 || q[0].is_err) begin
                    failures++;
                    $display("FAIL unexpected_flush at %0t: queue size %0d", $time, q.size());
                end else begin
                    e = q.pop_front();
                    exp_coef = e.coef;
                    exp_order = e.order;
                end
            end
            if (err) begin
                checks++;
                if (q.size() == 0 || !q[0].is_err) begin
                    failures++;
                    $display("FAIL unexpected_err at %0t: queue size %0d", $time, q.size());
                end else begin
                    e = q.pop_front();
                end
            end
            checks++;
            if (coef_out !== exp_coef) begin
                failures++;
                $display("FAIL coef_out at %0t: got %h expected %h", $time, coef_out, exp_coef);
            end
            chk("order_out", 32'(order_out), 32'(exp_order));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int gaps, input bit rnd_tick,
                             input bit tick_on_xfer);
        int g;
        int t;
        g = (gaps > 0) ? int'($urandom_range(0, gaps)) : 0;
        for (int i = 0; i < g; i++) begin
            s_valid = 1'b0;
            sample_tick = rnd_tick ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc(1);
        end
        s_valid = 1'b1;
        s_data = w;
        sample_tick = tick_on_xfer;
        t = 0;
        while (!s_ready && t < 20) begin
            cyc(1);
            t++;
        end
        if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'd1);
        cyc(1);
        s_valid = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            cyc(1);
            t++;
        end
        chk("event_drain", 32'(q.size()), 32'd0);
    endtask

    // Builds one frame from the model, sends it, and ticks tick_delay+1 cycles after the end
    task automatic send_frame(input logic [3:0] ord, input int gaps, input bit rnd_tick,
                              input bit seq, input bit bad_sum, input int tick_delay);
        ev_t           e;
        ev_t           ee;
        logic [DW-1:0] hdr;
        logic [DW-1:0] w;
        logic [DW-1:0] sum;
        int            n;
        hdr = seq ? {4'hA, 8'h00, ord} : {4'hA, 8'($urandom), ord};
        n = 5 * ((int'(ord) + 1) / 2);
        e.is_err = 1'b0;
        e.order = ord;
        e.coef = '0;
        sum = hdr;
        send_word(hdr, 0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            w = seq ? DW'(i + 1) : DW'($urandom);
            e.coef[i*DW +: DW] = w;
            sum = sum + w;
            send_word(w, gaps, rnd_tick, rnd_tick && (i == n - 1));
        end
`ifdef IIR_COEF_CHECKSUM_EN
        if (bad_sum) begin
            ee.is_err = 1'b1;
            ee.order = 4'd0;
            ee.coef = '0;
            q.push_back(ee);
            send_word(sum + DW'(1), 0, 1'b0, 1'b0);
            cyc(2);
            chk("sum_bad_idle", 32'(busy), 32'd0);
            drain();
            return;
        end
        send_word(sum, 0, 1'b0, 1'b0);
`else
        if (bad_sum) chk("bad_sum_unsupported", 32'd0, 32'd1);
`endif
        chk("pend_s_ready", 32'(s_ready), 32'd0);
        chk("pend_busy", 32'(busy), 32'd1);
        cyc(tick_delay);
        q.push_back(e);
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        chk("post_commit_busy", 32'(busy), 32'd0);
        drain();
    endtask

    task automatic bad_header(input logic [DW-1:0] h);
        ev_t e;
        e.is_err = 1'b1;
        e.order = 4'd0;
        e.coef = '0;
        q.push_back(e);
        send_word(h, 0, 1'b0, 1'b0);
        cyc(2);
        chk("bad_hdr_busy", 32'(busy), 32'd0);
        chk("bad_hdr_ready", 32'(s_ready), 32'd1);
        drain();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_coef_zero"}, 32'(|coef_out), 32'd0);
        chk({tag, "_order"}, 32'(order_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_flush_n"}, 32'(flush_n), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        check_reset_state("init");

        // Order 2 with counting coefficients, tick four cycles after the last word
        send_frame(4'd2, 0, 1'b0, 1'b1, 1'b0, 3);
        chk("t2_b0", 32'(coef_out[15:0]), 32'd1);
        chk("t2_a1", 32'(coef_out[63:48]), 32'd4);
        chk("t2_a2", 32'(coef_out[79:64]), 32'd5);
        chk("t2_upper_zero", 32'(|coef_out[BW-1:80]), 32'd0);
        chk("t2_order", 32'(order_out), 32'd2);

        // Rejected headers: wrong magic, order above max, order zero
        bad_header(16'hB004);
        bad_header(16'hA00F);
        bad_header(16'hA000);

        // Longer then shorter load: stale upper sections must be cleared
        send_frame(4'd6, 2, 1'b0, 1'b0, 1'b0, 1);
        send_frame(4'd3, 2, 1'b0, 1'b0, 1'b0, 2);
        chk("t5_upper_zero", 32'(|coef_out[BW-1:160]), 32'd0);
        chk("t5_order", 32'(order_out), 32'd3);

        // Full-order load with gaps and stray ticks over an active order-2 bank
        send_frame(4'd2, 0, 1'b0, 1'b0, 1'b0, 0);
        send_frame(4'd14, 3, 1'b1, 1'b0, 1'b0, 5);
        chk("t4_order", 32'(order_out), 32'd14);

        for (int k = 0; k < 6; k++) begin
            send_frame(4'($urandom_range(1, 14)), 2, 1'b1, 1'b0, 1'b0,
                       int'($urandom_range(0, 4)));
        end

        // Reset in the middle of a load clears both banks
        send_word(16'hA005, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_word(DW'($urandom), 0, 1'b0, 1'b0);
        chk("midload_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        check_reset_state("midload");

`ifdef IIR_COEF_CHECKSUM_EN
        send_frame(4'd1, 0, 1'b0, 1'b1, 1'b0, 1);
        chk("cs_b0", 32'(coef_out[15:0]), 32'd1);
        chk("cs_order", 32'(order_out), 32'd1);
        send_frame(4'd4, 1, 1'b0, 1'b1, 1'b1, 1);
        chk("cs_keep_order", 32'(order_out), 32'd1);
`endif

        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
